// File: rtl/uart_word_serializer.sv
// Buffers strobed words in a small FIFO and feeds their enabled byte lanes to a UART, one byte per tx_done handshake.
// Optional sticky overflow flag enabled by defining UART_SER_OVF_EN; otherwise ovf is tied low.
module uart_word_serializer #(
    parameter int BYTES     = 4,
    parameter int DEPTH     = 4,
    parameter int MSB_FIRST = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [8*BYTES-1:0]         wr_data,
    input  logic [BYTES-1:0]           wr_strb,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     level,
    input  logic                       tx_done,
    output logic                       tx_dv,
    output logic [7:0]                 tx_data,
    output logic                       busy,
    output logic                       ovf,
    input  logic                       ovf_clr
);

    localparam int PW  = $clog2(DEPTH);
    localparam int LVW = PW + 1;
    localparam int LW  = (BYTES > 1) ? $clog2(BYTES) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, SEND} state_t;

    state_t               state;
    logic [8*BYTES-1:0]   mem_data [DEPTH];
    logic [BYTES-1:0]     mem_strb [DEPTH];
    logic [PW-1:0]        wr_ptr;
    logic [PW-1:0]        rd_ptr;
    logic [8*BYTES-1:0]   hold_data;
    logic [BYTES-1:0]     mask;
    logic [LW-1:0]        cur_lane;
    logic                 wr_acc;
    logic                 pop;
    logic [8*BYTES-1:0]   load_word;
    logic [LW-1:0]        load_lane;
    logic [LW-1:0]        next_lane;

    // Priority pick over a lane mask; the last match in the scan wins.
    function automatic logic [LW-1:0] pick_lane(input logic [BYTES-1:0] m);
        logic [LW-1:0] idx;
        idx = '0;
        for (int k = 0; k < BYTES; k++) begin
            if (MSB_FIRST != 0) begin
                if (m[k]) idx = LW'(k);
            end else begin
                if (m[BYTES-1-k]) idx = LW'(BYTES-1-k);
            end
        end
        return idx;
    endfunction

    assign full      = (level == LVW'(DEPTH));
    assign busy      = (state != IDLE);
    assign wr_acc    = wr_en && !full && (wr_strb != '0);
    assign pop       = (state == LOAD);
    assign load_word = mem_data[rd_ptr];
    assign load_lane = pick_lane(mem_strb[rd_ptr]);
    assign next_lane = pick_lane(mask);

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem_data[wr_ptr] <= wr_data;
            mem_strb[wr_ptr] <= wr_strb;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
            if (pop)    rd_ptr <= rd_ptr + 1'b1;
            case ({wr_acc, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            hold_data <= '0;
            mask      <= '0;
            cur_lane  <= '0;
            tx_dv     <= 1'b0;
            tx_data   <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    if (level != '0) state <= LOAD;
                end
                LOAD: begin
                    hold_data <= load_word;
                    mask      <= mem_strb[rd_ptr];
                    cur_lane  <= load_lane;
                    tx_data   <= load_word[{load_lane, 3'b000} +: 8];
                    tx_dv     <= 1'b1;
                    state     <= SEND;
                end
                SEND: begin
                    if (tx_dv) begin
                        if (tx_done) begin
                            mask[cur_lane] <= 1'b0;
                            tx_dv          <= 1'b0;
                        end
                    end else if (mask != '0) begin
                        // The tx_dv-low cycle after each handshake doubles as the inter-byte gap.
                        cur_lane <= next_lane;
                        tx_data  <= hold_data[{next_lane, 3'b000} +: 8];
                        tx_dv    <= 1'b1;
                    end else if (level != '0) begin
                        state <= LOAD;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef UART_SER_OVF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (wr_en && (wr_strb != '0) && full) begin
            ovf <= 1'b1;
        end else if (ovf_clr) begin
            ovf <= 1'b0;
        end
    end
`else
    logic unused_ovf_clr;
    assign unused_ovf_clr = ovf_clr;
    assign ovf            = 1'b0;
`endif

endmodule

// File: tb/tb_uart_word_serializer.sv
// Directed bench for uart_word_serializer: expected bytes queued at stimulus time, checked by a negedge monitor.
module tb_uart_word_serializer;

    localparam int BYTES     = 4;
    localparam int DEPTH     = 4;
    localparam int MSB_FIRST = 0;
`ifdef UART_SER_OVF_EN
    localparam bit OVF_ON = 1'b1;
`else
    localparam bit OVF_ON = 1'b0;
`endif

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    wr_en = 1'b0;
    logic [8*BYTES-1:0]      wr_data = '0;
    logic [BYTES-1:0]        wr_strb = '0;
    logic                    full;
    logic [$clog2(DEPTH):0]  level;
    logic                    tx_done = 1'b0;
    logic                    tx_dv;
    logic [7:0]              tx_data;
    logic                    busy;
    logic                    ovf;
    logic                    ovf_clr = 1'b0;

    int checks = 0;
    int errors = 0;
    int nbytes = 0;
    int cyc = 0;
    bit resp_en = 1'b1;
    bit last_dv = 1'b0;
    logic [7:0] last_data = 8'h00;
    logic [7:0] exp_q [$];
    int rise_q [$];

    uart_word_serializer #(.BYTES(BYTES), .DEPTH(DEPTH), .MSB_FIRST(MSB_FIRST)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .wr_strb(wr_strb),
        .full(full), .level(level), .tx_done(tx_done), .tx_dv(tx_dv), .tx_data(tx_data),
        .busy(busy), .ovf(ovf), .ovf_clr(ovf_clr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor plus UART responder: tx_done answers a presented byte half a cycle later.
    always @(negedge clk) begin
        if (tx_dv && !last_dv) begin
            rise_q.push_back(cyc);
            nbytes++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_byte: got %0h expected none", tx_data);
            end else begin
                chk("tx_byte", tx_data, exp_q.pop_front());
            end
        end else if (tx_dv && last_dv) begin
            chk("tx_stable", tx_data, last_data);
        end
        last_dv   = tx_dv;
        last_data = tx_data;
        tx_done   = tx_dv && resp_en && !tx_done;
    end

    task automatic wr(input logic [31:0] d, input logic [3:0] s);
        wr_en   = 1'b1;
        wr_data = d;
        wr_strb = s;
        @(posedge clk);
        #1;
        wr_en   = 1'b0;
        wr_strb = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((busy || level != 0) && n < 300) begin
            tick();
            n++;
        end
        chk(name, busy, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int base;
        int n;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_level", level, 0);
        chk("rst_full", full, 0);
        chk("rst_tx_dv", tx_dv, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ovf", ovf, 0);
        rst = 1'b0;
        tick();

        // Full word, 2-cycle latency, and a write coinciding with the pop.
        if (MSB_FIRST != 0) begin
            exp_q.push_back(8'h44); exp_q.push_back(8'h33); exp_q.push_back(8'h22); exp_q.push_back(8'h11);
            exp_q.push_back(8'hBB); exp_q.push_back(8'hDD);
        end else begin
            exp_q.push_back(8'h11); exp_q.push_back(8'h22); exp_q.push_back(8'h33); exp_q.push_back(8'h44);
            exp_q.push_back(8'hDD); exp_q.push_back(8'hBB);
        end
        rise_q.delete();
        wr(32'h44332211, 4'b1111);
        chk("lat_n0_dv", tx_dv, 0);
        chk("lat_n0_level", level, 1);
        tick();
        chk("lat_n1_dv", tx_dv, 0);
        chk("lat_n1_busy", busy, 1);
        wr(32'hAABBCCDD, 4'b0101);
        chk("lat_n2_dv", tx_dv, 1);
        chk("lat_n2_data", tx_data, (MSB_FIRST != 0) ? 8'h44 : 8'h11);
        chk("wr_pop_level", level, 1);
        wait_idle("word1_idle");
        chk("word1_rises", rise_q.size(), 6);
        if (rise_q.size() >= 4) begin
            for (int k = 1; k < 4; k++) chk("byte_gap", rise_q[k] - rise_q[k-1], 2);
        end

        // Zero-strobe write is discarded.
        wr(32'hDEADBEEF, 4'b0000);
        chk("strb0_level", level, 0);
        repeat (3) tick();
        chk("strb0_busy", busy, 0);

        // Overflow: one word parked in SEND, then five writes into the FIFO.
        resp_en = 1'b0;
        if (MSB_FIRST != 0) begin
            exp_q.push_back(8'h04); exp_q.push_back(8'h03); exp_q.push_back(8'h02); exp_q.push_back(8'h01);
        end else begin
            exp_q.push_back(8'h01); exp_q.push_back(8'h02); exp_q.push_back(8'h03); exp_q.push_back(8'h04);
        end
        wr(32'h04030201, 4'b1111);
        n = 0;
        while (!tx_dv && n < 20) begin
            tick();
            n++;
        end
        chk("w0_present", tx_dv, 1);
        exp_q.push_back(8'hA1); exp_q.push_back(8'hA2); exp_q.push_back(8'hA3); exp_q.push_back(8'hA4);
        wr(32'h000000A1, 4'b0001);
        wr(32'h000000A2, 4'b0001);
        wr(32'h000000A3, 4'b0001);
        wr(32'h000000A4, 4'b0001);
        chk("ovf_pre_full", full, 1);
        wr(32'h000000A5, 4'b0001);
        chk("ovf_level", level, 4);
        chk("ovf_full", full, 1);
        chk("ovf_flag", ovf, OVF_ON);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("ovf_cleared", ovf, 0);
        chk("ovf_level_hold", level, 4);
        resp_en = 1'b1;
        wait_idle("ovf_drain_idle");

        // Reset after two of four bytes.
        if (MSB_FIRST != 0) begin
            exp_q.push_back(8'h0D); exp_q.push_back(8'h0C);
        end else begin
            exp_q.push_back(8'h0A); exp_q.push_back(8'h0B);
        end
        exp_q.push_back(8'hEE); exp_q.push_back(8'hEE);
        base = nbytes;
        wr(32'h0D0C0B0A, 4'b1111);
        n = 0;
        while ((nbytes - base) < 2 && n < 100) begin
            @(negedge clk);
            #2;
            n++;
        end
        chk("bytes_before_rst", nbytes - base, 2);
        rst = 1'b1;
        #1;
        chk("midrst_tx_dv", tx_dv, 0);
        chk("midrst_level", level, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_tx_data", tx_data, 0);
        exp_q.delete();
        tick();
        rst = 1'b0;
        repeat (12) tick();
        chk("no_bytes_after_rst", nbytes - base, 2);
        chk("post_rst_busy", busy, 0);
        chk("exp_q_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
